// File: rtl/la_wbm_pkg.sv
// Shared state encoding and response status codes for the Wishbone single-transfer initiator.
package la_wbm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_BUSERR  = 2'b10;

endpackage

// File: rtl/la_wbm_timeout.sv
// Wait-state counter for one bus cycle; expired_o flags the last cycle the initiator may wait,
// so a cycle with no ack lasts exactly TIMEOUT STB cycles.
module la_wbm_timeout #(
   parameter int TIMEOUT = 255,
   parameter int TW      = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/la_wb_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response pulse.
// Zero-wait ack gives rsp_valid two cycles after acceptance; LA_WBM_ERR_EN adds the wbm_err_i input.
module la_wb_master
   import la_wbm_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TW      = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   output logic [31:0] rsp_dat,
   output logic [1:0]  rsp_status,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
`ifdef LA_WBM_ERR_EN
   input  logic        wbm_err_i,
`endif
   input  logic        wbm_ack_i
);

   state_e      state_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_dat_q;
   logic [1:0]  rsp_status_q;
   logic        cyc_q;
   logic        stb_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;

   logic accept;
   logic bus_ack;
   logic bus_err;
   logic expired;

   assign accept  = (state_q == IDLE) & cmd_valid;
   assign bus_ack = (state_q == BUS) & wbm_ack_i;
`ifdef LA_WBM_ERR_EN
   assign bus_err = (state_q == BUS) & wbm_err_i;
`else
   assign bus_err = 1'b0;
`endif

   la_wbm_timeout #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_timeout (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .clr_i     (accept),
      .en_i      ((state_q == BUS) & ~wbm_ack_i & ~bus_err),
      .expired_o (expired)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= ST_OK;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q        <= cmd_we;
                  adr_q       <= cmd_adr;
                  dat_q       <= cmd_dat;
                  sel_q       <= cmd_sel;
                  cyc_q       <= 1'b1;
                  stb_q       <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  state_q     <= BUS;
               end
            end
            BUS: begin
               // err outranks ack, and any response outranks the timeout
               if (bus_err || bus_ack || expired) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
                  if (bus_err) begin
                     rsp_status_q <= ST_BUSERR;
                  end else if (bus_ack) begin
                     rsp_status_q <= ST_OK;
                     if (!we_q) begin
                        rsp_dat_q <= wbm_dat_i;
                     end
                  end else begin
                     rsp_status_q <= ST_TIMEOUT;
                  end
               end
            end
            RESP: begin
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               cmd_ready_q <= 1'b1;
               cyc_q       <= 1'b0;
               stb_q       <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_dat    = rsp_dat_q;
   assign rsp_status = rsp_status_q;
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = stb_q;
   assign wbm_we_o   = we_q;
   assign wbm_sel_o  = sel_q;
   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = dat_q;

endmodule
